// File: rtl/multi_channel_frame_source_if.sv
// AXI-Stream style bus carrying frame beats from multi_channel_frame_source.
// tuser carries the channel number of the frame in flight.
interface multi_channel_frame_source_if #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_W     = 2
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_W-1:0]     tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/multi_channel_frame_source.sv
// Round-robin multi-channel AXI-Stream frame generator: header, counter/LFSR payload.
// Define FRAME_CRC_EN to append a CRC-8 trailer beat to every frame.
module multi_channel_frame_source #(
  parameter int DATA_WIDTH   = 8,
  parameter int PAYLOAD_LEN  = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic                               enable,
  input  logic                               mode,
  multi_channel_frame_source_if.master       m_axis,
  output logic [15:0]                        frames_sent
);

  localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int SEQ_W  = DATA_WIDTH - CH_W;
  localparam int BEAT_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PAYLOAD_LEN - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CHANNELS - 1);
  // The IDLE cycle itself is the final idle cycle, so GAP lasts one cycle less.
  localparam logic [15:0]       GAP_LAST  = 16'(GAP_CYCLES - 2);
`ifdef FRAME_CRC_EN
  localparam bit PAYLOAD_TLAST = 1'b0;
`else
  localparam bit PAYLOAD_TLAST = 1'b1;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
`ifdef FRAME_CRC_EN
    S_CRC,
`endif
    S_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic                  mode_q, mode_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [15:0]           gap_q, gap_d;
  logic [15:0]           frames_q, frames_d;
  logic [SEQ_W-1:0]      seq_q [NUM_CHANNELS];
  logic [SEQ_W-1:0]      seq_d [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] cnt_q [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] cnt_d [NUM_CHANNELS];
  logic [15:0]           lfsr_q [NUM_CHANNELS];
  logic [15:0]           lfsr_d [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [CH_W-1:0]       tuser_q, tuser_d;

  logic                  handshake;
  logic                  frame_done;
  logic [15:0]           lfsr_adv;
  logic [DATA_WIDTH-1:0] cnt_adv;
  logic [DATA_WIDTH-1:0] gen_now;
  logic [DATA_WIDTH-1:0] gen_after;
  logic [DATA_WIDTH-1:0] hdr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

`ifdef FRAME_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic [7:0] crc_upd;

  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else                c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign crc_upd = crc8_next(crc_q, tdata_q[7:0]);
`endif

  assign handshake = tvalid_q && m_axis.tready;
  assign lfsr_adv  = lfsr_next(lfsr_q[ch_q]);
  assign cnt_adv   = cnt_q[ch_q] + 1'b1;
  assign gen_now   = mode_q ? lfsr_q[ch_q][DATA_WIDTH-1:0] : cnt_q[ch_q];
  assign gen_after = mode_q ? lfsr_adv[DATA_WIDTH-1:0] : cnt_adv;
  assign hdr       = {ch_q, seq_q[ch_q]};

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    ch_d       = ch_q;
    mode_d     = mode_q;
    beat_d     = beat_q;
    gap_d      = gap_q;
    frames_d   = frames_q;
    seq_d      = seq_q;
    cnt_d      = cnt_q;
    lfsr_d     = lfsr_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tuser_d    = tuser_q;
    frame_done = 1'b0;
`ifdef FRAME_CRC_EN
    crc_d      = crc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d  = S_HEADER;
          mode_d   = mode;
          tvalid_d = 1'b1;
          tdata_d  = hdr;
          tlast_d  = 1'b0;
          tuser_d  = ch_q;
        end
      end
      S_HEADER: begin
        if (handshake) begin
          state_d = S_PAYLOAD;
          beat_d  = '0;
          tdata_d = gen_now;
          tlast_d = PAYLOAD_TLAST && (LAST_BEAT == '0);
`ifdef FRAME_CRC_EN
          crc_d   = crc8_next(8'h00, tdata_q[7:0]);
`endif
        end
      end
      S_PAYLOAD: begin
        if (handshake) begin
          // Only the generator selected for this frame advances.
          if (mode_q) lfsr_d[ch_q] = lfsr_adv;
          else        cnt_d[ch_q]  = cnt_adv;
`ifdef FRAME_CRC_EN
          crc_d = crc_upd;
`endif
          if (beat_q == LAST_BEAT) begin
`ifdef FRAME_CRC_EN
            state_d = S_CRC;
            tdata_d = DATA_WIDTH'(crc_upd);
            tlast_d = 1'b1;
`else
            frame_done = 1'b1;
`endif
          end else begin
            beat_d  = beat_q + 1'b1;
            tdata_d = gen_after;
            tlast_d = PAYLOAD_TLAST && (BEAT_W'(beat_q + 1'b1) == LAST_BEAT);
          end
        end
      end
`ifdef FRAME_CRC_EN
      S_CRC: begin
        if (handshake) frame_done = 1'b1;
      end
`endif
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_done) begin
      seq_d[ch_q] = seq_q[ch_q] + 1'b1;
      ch_d        = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
      frames_d    = frames_q + 1'b1;
      tvalid_d    = 1'b0;
      tlast_d     = 1'b0;
      gap_d       = '0;
      state_d     = (GAP_CYCLES > 1) ? S_GAP : S_IDLE;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      mode_q   <= 1'b0;
      beat_q   <= '0;
      gap_q    <= '0;
      frames_q <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= '0;
      // NOTE: per-channel state is a small flop array, not RAM, so resetting it is cheap and required.
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        seq_q[c]  <= '0;
        cnt_q[c]  <= '0;
        lfsr_q[c] <= 16'hACE1 ^ 16'(c);
      end
`ifdef FRAME_CRC_EN
      crc_q    <= '0;
`endif
    end else begin
      // NOTE: state updates use <= so every flop samples the pre-edge values of the others.
      state_q  <= state_d;
      ch_q     <= ch_d;
      mode_q   <= mode_d;
      beat_q   <= beat_d;
      gap_q    <= gap_d;
      frames_q <= frames_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      seq_q    <= seq_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
`ifdef FRAME_CRC_EN
      crc_q    <= crc_d;
`endif
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;
  assign frames_sent   = frames_q;

endmodule

// File: tb/tb_multi_channel_frame_source.sv
// Scoreboard bench for multi_channel_frame_source: default 4-channel instance plus
// a single-channel instance for sequence-number wrap.
module tb_multi_channel_frame_source;

  localparam int NC  = 4;
  localparam int PL  = 8;
  localparam int GAP = 4;
`ifdef FRAME_CRC_EN
  localparam bit CRC = 1'b1;
`else
  localparam bit CRC = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       tlast;
    logic [1:0] user;
  } beat_t;

  logic        aclk = 1'b0;
  logic        areset, enable, mode;
  logic [15:0] frames_sent;
  logic        rst_b, enable_b;
  logic [15:0] frames_sent_b;

  always #5 aclk = ~aclk;

  multi_channel_frame_source_if #(.DATA_WIDTH(8), .USER_W(2)) axis_a ();
  multi_channel_frame_source_if #(.DATA_WIDTH(8), .USER_W(1)) axis_b ();

  multi_channel_frame_source dut (
    .aclk(aclk), .areset(areset), .enable(enable), .mode(mode),
    .m_axis(axis_a), .frames_sent(frames_sent)
  );

  multi_channel_frame_source #(.NUM_CHANNELS(1)) dut_b (
    .aclk(aclk), .areset(rst_b), .enable(enable_b), .mode(1'b0),
    .m_axis(axis_b), .frames_sent(frames_sent_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Reference model of the four-channel instance.
  logic [1:0]  m_ch;
  logic [5:0]  m_seq  [NC];
  logic [7:0]  m_cnt  [NC];
  logic [15:0] m_lfsr [NC];
  beat_t       exp_q[$];

  task automatic model_reset();
    m_ch = '0;
    for (int c = 0; c < NC; c++) begin
      m_seq[c]  = '0;
      m_cnt[c]  = '0;
      m_lfsr[c] = 16'hACE1 ^ 16'(c);
    end
  endtask

  task automatic push_frame(input logic md);
    logic [7:0]  hdr, v, crc;
    logic [15:0] s;
    hdr = {m_ch, m_seq[m_ch]};
    exp_q.push_back('{data: hdr, tlast: 1'b0, user: m_ch});
    crc = crc8(8'h00, hdr);
    for (int i = 0; i < PL; i++) begin
      v = md ? m_lfsr[m_ch][7:0] : m_cnt[m_ch];
      exp_q.push_back('{data: v, tlast: (i == PL - 1) && !CRC, user: m_ch});
      crc = crc8(crc, v);
      if (md) begin
        s = m_lfsr[m_ch];
        m_lfsr[m_ch] = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
      end else begin
        m_cnt[m_ch] = m_cnt[m_ch] + 8'd1;
      end
    end
    if (CRC) exp_q.push_back('{data: crc, tlast: 1'b1, user: m_ch});
    m_seq[m_ch] = m_seq[m_ch] + 6'd1;
    m_ch = (m_ch == 2'(NC - 1)) ? 2'd0 : m_ch + 2'd1;
  endtask

  // Monitor for the four-channel instance.
  int         beat_idx = 0;
  int         gap_cnt  = 0;
  bit         gap_pending = 1'b0;
  bit         gap_chk = 1'b0;
  bit         prev_stall = 1'b0;
  logic [11:0] prev_vec;
  beat_t      got_b;

  always @(negedge aclk) begin
    if (areset) begin
      beat_idx    = 0;
      gap_pending = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {axis_a.tvalid, axis_a.tlast, axis_a.tuser, axis_a.tdata}, prev_vec);
      prev_stall = axis_a.tvalid && !axis_a.tready;
      prev_vec   = {axis_a.tvalid, axis_a.tlast, axis_a.tuser, axis_a.tdata};
      if (!gap_chk) gap_pending = 1'b0;
      if (gap_pending) begin
        if (!axis_a.tvalid) gap_cnt++;
        else begin
          check("gap_cycles", gap_cnt, GAP);
          gap_pending = 1'b0;
        end
      end
      if (axis_a.tvalid && axis_a.tready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(exp_q.size()), 1);
        end else begin
          got_b = exp_q.pop_front();
          check("tdata", axis_a.tdata, got_b.data);
          check("tlast", axis_a.tlast, got_b.tlast);
          check("tuser", axis_a.tuser, got_b.user);
        end
        if (axis_a.tlast) begin
          beat_idx = 0;
          if (gap_chk) begin
            gap_pending = 1'b1;
            gap_cnt     = 0;
          end
        end else begin
          beat_idx++;
        end
      end
    end
  end

  // Monitor for the single-channel instance (header = 7-bit sequence, counter payload).
  int         b_idx = 0;
  logic [6:0] b_seq;
  logic [7:0] b_cnt, b_crc, b_exp, b_last_hdr, b_prev_hdr;
  logic       b_exp_last;

  always @(negedge aclk) begin
    if (rst_b) begin
      b_idx      = 0;
      b_seq      = '0;
      b_cnt      = '0;
      b_crc      = '0;
      b_last_hdr = 8'hFF;
      b_prev_hdr = 8'hFF;
    end else if (axis_b.tvalid && axis_b.tready) begin
      if (b_idx == 0) begin
        b_exp      = {1'b0, b_seq};
        b_crc      = crc8(8'h00, b_exp);
        b_prev_hdr = b_last_hdr;
        b_last_hdr = axis_b.tdata;
      end else if (b_idx <= PL) begin
        b_exp = b_cnt;
        b_cnt = b_cnt + 8'd1;
        b_crc = crc8(b_crc, b_exp);
      end else begin
        b_exp = b_crc;
      end
      b_exp_last = CRC ? (b_idx == PL + 1) : (b_idx == PL);
      check("b_tdata", axis_b.tdata, b_exp);
      check("b_tlast", axis_b.tlast, b_exp_last);
      check("b_tuser", axis_b.tuser, 0);
      if (axis_b.tlast) begin
        b_idx = 0;
        b_seq = b_seq + 7'd1;
      end else begin
        b_idx++;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic run_frames(input int n, input logic md, input bit rnd);
    int target, cyc;
    target = int'(frames_sent) + n;
    for (int k = 0; k < n; k++) push_frame(md);
    mode   = md;
    enable = 1'b1;
    cyc    = 0;
    while (frames_sent != 16'(target) && cyc < n * 60) begin
      tick();
      if (rnd) axis_a.tready = 1'($urandom_range(0, 1));
      cyc++;
    end
    gap_chk       = 1'b0;
    enable        = 1'b0;
    axis_a.tready = 1'b1;
    check("frames_sent", frames_sent, 32'(16'(target)));
    repeat (8) tick();
    check("sb_drained", 32'(exp_q.size()), 0);
    check("idle_after", axis_a.tvalid, 0);
  endtask

  task automatic wait_beat3();
    int cyc;
    cyc = 0;
    while (!(axis_a.tvalid && beat_idx == 3) && cyc < 50) begin
      tick();
      cyc++;
    end
    check("reached_beat3", beat_idx, 3);
  endtask

  initial begin
    int  base, cyc;
    bit  saw;
    areset        = 1'b1;
    enable        = 1'b0;
    mode          = 1'b0;
    axis_a.tready = 1'b1;
    rst_b         = 1'b1;
    enable_b      = 1'b0;
    axis_b.tready = 1'b1;
    model_reset();
    repeat (3) tick();
    areset = 1'b0;

    check("rst_tvalid", axis_a.tvalid, 0);
    check("rst_tlast", axis_a.tlast, 0);
    check("rst_tdata", axis_a.tdata, 0);
    check("rst_tuser", axis_a.tuser, 0);
    check("rst_frames", frames_sent, 0);

    // Counter mode, full round plus wrap back to channel 0.
    gap_chk = 1'b1;
    run_frames(5, 1'b0, 1'b0);

    // LFSR mode, starting at channel 1.
    run_frames(4, 1'b1, 1'b0);

    // Random backpressure.
    gap_chk = 1'b1;
    run_frames(20, 1'b0, 1'b1);

    // enable dropped mid-frame: frame completes, nothing new starts.
    base = int'(frames_sent);
    push_frame(1'b0);
    mode   = 1'b0;
    enable = 1'b1;
    wait_beat3();
    enable = 1'b0;
    cyc = 0;
    while (frames_sent != 16'(base + 1) && cyc < 50) begin
      tick();
      cyc++;
    end
    check("en_drop_frames", frames_sent, 32'(16'(base + 1)));
    saw = 1'b0;
    repeat (20) begin
      tick();
      saw = saw | axis_a.tvalid;
    end
    check("en_drop_no_restart", saw, 0);
    check("en_drop_sb_drained", 32'(exp_q.size()), 0);

    // Reset mid-frame aborts without tlast and restores all state.
    push_frame(1'b0);
    enable = 1'b1;
    wait_beat3();
    areset = 1'b1;
    enable = 1'b0;
    exp_q.delete();
    model_reset();
    tick();
    check("abort_tvalid", axis_a.tvalid, 0);
    check("abort_tlast", axis_a.tlast, 0);
    check("abort_tdata", axis_a.tdata, 0);
    check("abort_tuser", axis_a.tuser, 0);
    check("abort_frames", frames_sent, 0);
    areset = 1'b0;
    run_frames(4, 1'b0, 1'b0);
    run_frames(1, 1'b1, 1'b0);

    // Single-channel instance: 7-bit sequence wraps after 128 frames.
    rst_b    = 1'b0;
    enable_b = 1'b1;
    cyc = 0;
    while (frames_sent_b != 16'd128 && cyc < 128 * 20) begin
      tick();
      cyc++;
    end
    check("b_frames_128", frames_sent_b, 128);
    cyc = 0;
    while (frames_sent_b != 16'd129 && cyc < 40) begin
      tick();
      cyc++;
    end
    enable_b = 1'b0;
    check("b_frames_129", frames_sent_b, 129);
    check("b_hdr_before_wrap", b_prev_hdr, 8'h7F);
    check("b_hdr_after_wrap", b_last_hdr, 8'h00);
    repeat (10) tick();
    check("b_idle_after", axis_b.tvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
